screen_sequencer: RTL and testbench
===================================

// Module: screen_sequencer
// PURPOSE
//  Top-level game-flow controller. Sequences the four full-screen renderers: START, CAPTURE, PLAY and OVER.
//  Picks the active screen and muxes its 12-bit pixel to the display.
//  Gates the centre-button pulse to the active screen and times the CAPTURE, PLAY and OVER phases in frames.
//  All screen changes happen only on a frame boundary (hcount_in==0 && vcount_in==0), so the display never tears.
// PARAMETERS
//  CAPTURE_FRAMES  180   frames spent in CAPTURE before PLAY (>=1)
//  PLAY_FRAMES     1800  frame limit for PLAY before forced OVER (>=1)
//  OVER_FRAMES     600   frames in OVER before auto-return to START (>=1)
//  FRAME_CNT_W     12    frame counter width; every *_FRAMES value must be < 2**FRAME_CNT_W
// PORTS
//  clk_in            in   1   pixel clock; the only clock
//  rst_in            in   1   synchronous, active-high reset
//  hcount_in         in   11  horizontal pixel count
//  vcount_in         in   10  vertical pixel count
//  btnc_in           in   1   debounced centre-button level
//  sw_hold_in        in   1   1 = freeze the FSM (debug); pending requests are kept
//  start_over_in     in   1   START screen finished (its state_1_over)
//  play_over_in      in   1   PLAY screen reports game end
//  pixel_start_in    in   12  START renderer pixel
//  pixel_capture_in  in   12  CAPTURE renderer pixel
//  pixel_play_in     in   12  PLAY renderer pixel
//  pixel_over_in     in   12  OVER renderer pixel
//  screen_sel_out    out  2   current screen (screen_t)
//  screen_start_out  out  1   1-cycle pulse on entering a screen; resets that renderer
//  btnc_pressed_out  out  1   1-cycle rising-edge pulse, forwarded in START and OVER only
//  countdown_out     out  FRAME_CNT_W  frames left in the current timed phase; 0 in START
//  over_reason_out   out  1   0 = PLAY ended by play_over_in, 1 = PLAY timed out
//  pixel_out         out  12  selected pixel, registered
// BEHAVIOUR
//  Reset values: screen_sel=START, screen_start=0, btnc_pressed=0, countdown=0, over_reason=0, pixel_out=0.
//   The first cycle after rst_in falls: screen_start_out=1 (START entry).
//  fb = (hcount_in==0 && vcount_in==0), combinational.
//   A transition decided at cycle t: screen_sel_out, countdown_out and screen_start_out=1 all appear at t+1.
//  Requests are latched as pending flags, pulse or level.
//   start_over_in counts only in START; play_over_in counts only in PLAY; otherwise ignored.
//   A request arriving on the fb cycle itself acts on that boundary.
//  Button edge = btnc_in & ~btnc_q. One pulse per press, however long the button is held.
//  Transitions (each waits for fb, and is blocked while sw_hold_in=1):
//   START   -> CAPTURE  when start_over pending; load counter = CAPTURE_FRAMES
//   CAPTURE -> PLAY     at the fb where counter==1; load counter = PLAY_FRAMES
//   PLAY    -> OVER     when play_over pending (reason 0), or at the fb where counter==1 (reason 1)
//                       If both happen on one fb, reason=0. Load counter = OVER_FRAMES.
//   OVER    -> START    when a button edge is pending, or at the fb where counter==1; counter=0
//  Counter: decrements at each fb in a timed state when no transition is taken. The entry fb is not counted.
//   So each timed phase lasts exactly N frames, and the counter never wraps below 1.
//  An edge seen in OVER is latched as pending until the next fb.
//   Edges in CAPTURE/PLAY are dropped and not forwarded.
//  pixel_out = the input selected by screen_sel_out, registered (latency 1).
//   The new screen's pixels appear from t+2.
//  All pending flags clear on any transition, and on reset.
//  Reset in mid-phase: everything returns to START on the next cycle.
// CONFIGURATION
//  CAPTURE_SKIP_EN defined: a button edge in CAPTURE ends the phase at the next fb, as if counter==1.
//  CAPTURE_SKIP_EN undefined: button edges are ignored in CAPTURE.
// STRUCTURE
//  Shared package game_pkg:
//   typedef enum logic [1:0] screen_t {SCR_START=0, SCR_CAPTURE=1, SCR_PLAY=2, SCR_OVER=3}
//   localparam logic [11:0] PIX_BLACK = 12'h000
//  Sub-module frame_timer: load, decrement on fb, expire flag at counter==1. Instantiated once.
// TESTING
//  Reset pulse -> screen_sel=0, pixel_out=0; screen_start_out high for exactly 1 cycle after release.
//  START, start_over_in pulse at h=100,v=150 -> sel stays 0 until fb; sel=1 and countdown=CAPTURE_FRAMES on the next cycle.
//  CAPTURE_FRAMES=3 -> sel=2 on the cycle after the 3rd fb following entry; countdown 3,2,1.
//  PLAY_FRAMES=2, play_over_in on the cycle of the 2nd fb -> sel=3, over_reason=0; with no play_over_in -> over_reason=1.
//  OVER, btnc_in held for 3 frames -> exactly 1 btnc_pressed_out pulse, sel=0 after the next fb.
//   sw_hold_in=1 -> sel frozen; after release, the pending transition is taken at the next fb.
//  CAPTURE_SKIP_EN on/off: press in CAPTURE -> PLAY at the next fb / no effect.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared screen encoding and pixel constants for the game flow.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  typedef enum logic [1:0] {
    SCR_START   = 2'd0,
    SCR_CAPTURE = 2'd1,
    SCR_PLAY    = 2'd2,
    SCR_OVER    = 2'd3
  } screen_t;

  localparam logic [11:0] PIX_BLACK = 12'h000;

endpackage : game_pkg
`default_nettype wire

// File: rtl/frame_timer.sv
`default_nettype none
// ============================================================================
// Module      : frame_timer
// Description : Loadable frame down-counter. Load has priority over
//               decrement; o_expire flags the last frame of a phase
//               (count == 1).
// Ports       : clk_in, rst_in   - clock, synchronous active-high reset
//               i_load/i_load_val - load a new frame count
//               i_dec             - decrement by one (frame boundary)
//               o_count           - current count
//               o_expire          - count == 1
// Revision    : 1.0 - initial release
// ============================================================================
module frame_timer #(
  parameter int FRAME_CNT_W = 12
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   i_load,
  input  logic [FRAME_CNT_W-1:0] i_load_val,
  input  logic                   i_dec,
  output logic [FRAME_CNT_W-1:0] o_count,
  output logic                   o_expire
);

  logic [FRAME_CNT_W-1:0] r_count;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      // Zero guard keeps the counter from wrapping if ever decremented at rest.
      r_count <= r_count - FRAME_CNT_W'(1);
    end
  end

  assign o_count  = r_count;
  assign o_expire = (r_count == FRAME_CNT_W'(1));

endmodule : frame_timer
`default_nettype wire

// File: rtl/screen_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : screen_sequencer
// Description : Game-flow controller. Selects START / CAPTURE / PLAY / OVER,
//               muxes the active renderer pixel, gates the centre button and
//               times the timed phases in frames. Screen changes only happen
//               on a frame boundary (hcount_in == 0 && vcount_in == 0).
// Ports       : clk_in, rst_in      - pixel clock, synchronous active-high reset
//               hcount_in/vcount_in - raster position
//               btnc_in, sw_hold_in - button level, debug freeze
//               start_over_in, play_over_in - screen completion requests
//               pixel_*_in          - renderer pixels
//               screen_sel_out, screen_start_out, btnc_pressed_out,
//               countdown_out, over_reason_out, pixel_out
// Config      : CAPTURE_SKIP_EN - a button edge in CAPTURE ends the phase at
//               the next frame boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module screen_sequencer
  import game_pkg::*;
#(
  parameter int CAPTURE_FRAMES = 180,
  parameter int PLAY_FRAMES    = 1800,
  parameter int OVER_FRAMES    = 600,
  parameter int FRAME_CNT_W    = 12
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   btnc_in,
  input  logic                   sw_hold_in,
  input  logic                   start_over_in,
  input  logic                   play_over_in,
  input  logic [11:0]            pixel_start_in,
  input  logic [11:0]            pixel_capture_in,
  input  logic [11:0]            pixel_play_in,
  input  logic [11:0]            pixel_over_in,
  output logic [1:0]             screen_sel_out,
  output logic                   screen_start_out,
  output logic                   btnc_pressed_out,
  output logic [FRAME_CNT_W-1:0] countdown_out,
  output logic                   over_reason_out,
  output logic [11:0]            pixel_out
);

  localparam logic [FRAME_CNT_W-1:0] c_capture_load = FRAME_CNT_W'(CAPTURE_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] c_play_load    = FRAME_CNT_W'(PLAY_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] c_over_load    = FRAME_CNT_W'(OVER_FRAMES);

  screen_t     r_sel;
  logic        r_screen_start;
  logic        r_btnc_pressed;
  logic        r_over_reason;
  logic [11:0] r_pix;
  logic        r_btnc_q;
  logic        r_in_rst;       // high while in reset: produces the START entry pulse
  logic        r_start_pend;
  logic        r_play_pend;
  logic        r_btn_pend;
`ifdef CAPTURE_SKIP_EN
  logic        r_skip_pend;
`endif

  logic                   w_fb;
  logic                   w_step;
  logic                   w_edge;
  logic                   w_start_req;
  logic                   w_play_req;
  logic                   w_btn_req;
  logic                   w_skip_req;
  logic                   w_expire;
  logic                   w_trans;
  logic                   w_dec;
  logic [FRAME_CNT_W-1:0] w_load_val;
  screen_t                w_next;

  assign w_fb   = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign w_step = w_fb & ~sw_hold_in;
  assign w_edge = btnc_in & ~r_btnc_q;

  // Requests include this cycle's event so one arriving on the boundary acts there.
  assign w_start_req = r_start_pend | (start_over_in && (r_sel == SCR_START));
  assign w_play_req  = r_play_pend  | (play_over_in  && (r_sel == SCR_PLAY));
  assign w_btn_req   = r_btn_pend   | (w_edge        && (r_sel == SCR_OVER));
`ifdef CAPTURE_SKIP_EN
  assign w_skip_req  = r_skip_pend  | (w_edge        && (r_sel == SCR_CAPTURE));
`else
  assign w_skip_req  = 1'b0;
`endif

  always_comb begin
    w_next     = r_sel;
    w_trans    = 1'b0;
    w_load_val = '0;
    unique case (r_sel)
      SCR_START: if (w_step && w_start_req) begin
        w_next = SCR_CAPTURE; w_trans = 1'b1; w_load_val = c_capture_load;
      end
      SCR_CAPTURE: if (w_step && (w_expire || w_skip_req)) begin
        w_next = SCR_PLAY; w_trans = 1'b1; w_load_val = c_play_load;
      end
      SCR_PLAY: if (w_step && (w_play_req || w_expire)) begin
        w_next = SCR_OVER; w_trans = 1'b1; w_load_val = c_over_load;
      end
      SCR_OVER: if (w_step && (w_btn_req || w_expire)) begin
        w_next = SCR_START; w_trans = 1'b1; w_load_val = '0;
      end
      default: ;
    endcase
  end

  // The entry boundary loads instead of decrementing, so each phase lasts N frames.
  assign w_dec = w_step && !w_trans && (r_sel != SCR_START);

  frame_timer #(
    .FRAME_CNT_W (FRAME_CNT_W)
  ) u_frame_timer (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_load     (w_trans),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_count    (countdown_out),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sel          <= SCR_START;
      r_screen_start <= 1'b0;
      r_btnc_pressed <= 1'b0;
      r_over_reason  <= 1'b0;
      r_pix          <= PIX_BLACK;
      r_btnc_q       <= 1'b0;
      r_in_rst       <= 1'b1;
      r_start_pend   <= 1'b0;
      r_play_pend    <= 1'b0;
      r_btn_pend     <= 1'b0;
`ifdef CAPTURE_SKIP_EN
      r_skip_pend    <= 1'b0;
`endif
    end else begin
      r_in_rst       <= 1'b0;
      r_btnc_q       <= btnc_in;
      r_screen_start <= w_trans | r_in_rst;
      r_btnc_pressed <= w_edge && ((r_sel == SCR_START) || (r_sel == SCR_OVER));
      r_sel          <= w_next;

      if (w_trans && (r_sel == SCR_PLAY))
        r_over_reason <= ~w_play_req;   // a play_over request wins over timeout

      // Pending flags hold across sw_hold_in and clear on any transition.
      r_start_pend <= w_start_req & ~w_trans;
      r_play_pend  <= w_play_req  & ~w_trans;
      r_btn_pend   <= w_btn_req   & ~w_trans;
`ifdef CAPTURE_SKIP_EN
      r_skip_pend  <= w_skip_req  & ~w_trans;
`endif

      unique case (r_sel)
        SCR_START:   r_pix <= pixel_start_in;
        SCR_CAPTURE: r_pix <= pixel_capture_in;
        SCR_PLAY:    r_pix <= pixel_play_in;
        SCR_OVER:    r_pix <= pixel_over_in;
        default:     r_pix <= PIX_BLACK;
      endcase
    end
  end

  assign screen_sel_out   = r_sel;
  assign screen_start_out = r_screen_start;
  assign btnc_pressed_out = r_btnc_pressed;
  assign over_reason_out  = r_over_reason;
  assign pixel_out        = r_pix;

endmodule : screen_sequencer
`default_nettype wire

// File: tb/tb_screen_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_screen_sequencer
// Description : Self-checking bench for screen_sequencer using a phase-level
//               reference model (frames elapsed since screen entry).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_screen_sequencer;

  localparam int CAP  = 3;
  localparam int PLAY = 2;
  localparam int OVR  = 5;
  localparam int HW   = 10;   // short raster: only the frame boundary matters
  localparam int VH   = 5;

  logic        clk = 1'b0;
  logic        rst, btn, hold, so, po;
  logic [10:0] h;
  logic [9:0]  v;
  logic [11:0] ps, pc, pp, pov;
  logic [1:0]  sel;
  logic        sstart, press, reason;
  logic [11:0] cd, pix;

  always #5 clk = ~clk;

  screen_sequencer #(
    .CAPTURE_FRAMES (CAP),
    .PLAY_FRAMES    (PLAY),
    .OVER_FRAMES    (OVR),
    .FRAME_CNT_W    (12)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .hcount_in        (h),
    .vcount_in        (v),
    .btnc_in          (btn),
    .sw_hold_in       (hold),
    .start_over_in    (so),
    .play_over_in     (po),
    .pixel_start_in   (ps),
    .pixel_capture_in (pc),
    .pixel_play_in    (pp),
    .pixel_over_in    (pov),
    .screen_sel_out   (sel),
    .screen_start_out (sstart),
    .btnc_pressed_out (press),
    .countdown_out    (cd),
    .over_reason_out  (reason),
    .pixel_out        (pix)
  );

  int total = 0;
  int bad   = 0;
  int n_press = 0;

  // Reference model state
  int          m_sel, m_cd, elapsed;
  bit          m_start, m_press, m_reason, m_in_rst, m_prev_btn;
  bit          q_s, q_p, q_b, q_k;
  logic [11:0] m_pix;
  bit          last_fb;

  function automatic int limit(input int s);
    case (s)
      1: return CAP;
      2: return PLAY;
      3: return OVR;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Expected outputs after the clock edge, from the inputs applied before it.
  task automatic model_step();
    bit e_btn, fb, expire;
    int nxt;
    if (rst) begin
      m_sel = 0; m_cd = 0; m_start = 0; m_press = 0; m_reason = 0; m_pix = '0;
      m_in_rst = 1; m_prev_btn = 0; q_s = 0; q_p = 0; q_b = 0; q_k = 0; elapsed = 0;
      return;
    end
    e_btn = btn && !m_prev_btn;
    m_prev_btn = btn;
    fb = (h == 0) && (v == 0);
    case (m_sel)
      0: m_pix = ps;
      1: m_pix = pc;
      2: m_pix = pp;
      default: m_pix = pov;
    endcase
    m_press = e_btn && (m_sel == 0 || m_sel == 3);
    if (m_sel == 0 && so) q_s = 1;
    if (m_sel == 2 && po) q_p = 1;
    if (m_sel == 3 && e_btn) q_b = 1;
`ifdef CAPTURE_SKIP_EN
    if (m_sel == 1 && e_btn) q_k = 1;
`endif
    m_start = m_in_rst;
    m_in_rst = 0;
    nxt = m_sel;
    expire = (m_sel != 0) && (limit(m_sel) - elapsed == 1);
    if (fb && !hold) begin
      case (m_sel)
        0: if (q_s) nxt = 1;
        1: if (expire || q_k) nxt = 2;
        2: if (q_p) begin nxt = 3; m_reason = 0; end
           else if (expire) begin nxt = 3; m_reason = 1; end
        default: if (q_b || expire) nxt = 0;
      endcase
      if (nxt != m_sel) begin
        m_sel = nxt; elapsed = 0; m_start = 1;
        q_s = 0; q_p = 0; q_b = 0; q_k = 0;
      end else if (m_sel != 0) begin
        elapsed++;
      end
    end
    m_cd = (m_sel == 0) ? 0 : limit(m_sel) - elapsed;
  endtask

  task automatic tick();
    @(posedge clk);
    last_fb = (h == 0) && (v == 0);
    model_step();
    #1;
    chk("sel",    32'(sel),    32'(m_sel));
    chk("start",  32'(sstart), 32'(m_start));
    chk("press",  32'(press),  32'(m_press));
    chk("cd",     32'(cd),     32'(m_cd));
    chk("reason", 32'(reason), 32'(m_reason));
    chk("pix",    32'(pix),    32'(m_pix));
    n_press += int'(press);
    if (h >= 11'(HW - 1)) begin
      h = '0;
      v = (v >= 10'(VH - 1)) ? 10'd0 : v + 10'd1;
    end else begin
      h = h + 11'd1;
    end
    ps = 12'($urandom); pc = 12'($urandom); pp = 12'($urandom); pov = 12'($urandom);
  endtask

  task automatic run_frames(input int n);
    int k = 0;
    for (int c = 0; c < n * HW * VH + HW * VH && k < n; c++) begin
      tick();
      if (last_fb) k++;
    end
    chk("frame_budget", 32'(k), 32'(n));
  endtask

  initial begin
    rst = 1; btn = 0; hold = 0; so = 0; po = 0; h = 11'd5; v = 10'd2;
    ps = '0; pc = '0; pp = '0; pov = '0;
    repeat (3) tick();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_pix", 32'(pix), 32'd0);
    rst = 0;
    tick();
    chk("entry_pulse", 32'(sstart), 32'd1);
    tick();
    chk("entry_pulse_end", 32'(sstart), 32'd0);

    // start_over mid-frame: nothing until the boundary
    h = 11'd100; v = 10'd150; so = 1; tick(); so = 0;
    chk("sel_before_fb", 32'(sel), 32'd0);
    h = 11'(HW - 2); v = 10'(VH - 1);
    tick(); tick();
    chk("sel_wait_fb", 32'(sel), 32'd0);
    tick();
    chk("cap_sel", 32'(sel), 32'd1);
    chk("cap_cd",  32'(cd), 32'(CAP));
    run_frames(1); chk("cap_cd2", 32'(cd), 32'(CAP - 1));
    run_frames(1); chk("cap_cd1", 32'(cd), 32'd1);
    run_frames(1); chk("play_sel", 32'(sel), 32'd2);
    chk("play_cd", 32'(cd), 32'(PLAY));

    // play_over arriving on the final boundary: reason 0
    run_frames(1);
    repeat (HW * VH - 1) tick();
    po = 1; tick(); po = 0;
    chk("over_sel", 32'(sel), 32'd3);
    chk("over_reason0", 32'(reason), 32'd0);

    // held button in OVER: a single pulse, back to START at next boundary
    n_press = 0; btn = 1;
    run_frames(1);
    chk("over_to_start", 32'(sel), 32'd0);
    run_frames(2);
    btn = 0; tick();
    chk("one_press", 32'(n_press), 32'd1);

    // timed-out PLAY: reason 1
    so = 1; tick(); so = 0;
    run_frames(1 + CAP + PLAY);
    chk("timeout_sel", 32'(sel), 32'd3);
    chk("timeout_reason1", 32'(reason), 32'd1);

    // hold freezes the FSM, keeps the pending press
    hold = 1; btn = 1; tick(); btn = 0;
    run_frames(2);
    chk("hold_frozen", 32'(sel), 32'd3);
    hold = 0;
    run_frames(1);
    chk("hold_released", 32'(sel), 32'd0);

    // button in CAPTURE
    so = 1; tick(); so = 0;
    run_frames(1);
    btn = 1; tick(); btn = 0;
    run_frames(1);
`ifdef CAPTURE_SKIP_EN
    chk("cap_skip", 32'(sel), 32'd2);
`else
    chk("cap_noskip", 32'(sel), 32'd1);
`endif

    // reset in mid-phase
    rst = 1; tick(); rst = 0;
    chk("midrst_sel", 32'(sel), 32'd0);
    tick();
    chk("midrst_pulse", 32'(sstart), 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      rst = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 299) == 0) hold = ~hold;
      if ($urandom_range(0, 39) == 0) btn = ~btn;
      so = ($urandom_range(0, 99) == 0);
      po = ($urandom_range(0, 149) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_screen_sequencer
`default_nettype wire
